seg7_scan_driver: RTL and testbench

//  Downstream consumer of the debounced BCD switch counters. Latches DIGITS packed BCD values,

---
 rtl/seg7_scan_if.sv | 16 +
 rtl/seg7_scan_driver.sv | 171 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Bus bundle between a BCD source and seg7_scan_driver: load strobe with packed
// digits in one direction, multiplexed segment/anode drive and frame pulse in the other.
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic                  LOAD;
    logic [4*DIGITS-1:0]   BCD;
    logic [DIGITS-1:0]     DP_IN;
    logic [6:0]            SEG;
    logic                  DP;
    logic [DIGITS-1:0]     AN;
    logic                  FRAME;

    modport master (output LOAD, BCD, DP_IN, input  SEG, DP, AN, FRAME);
    modport slave  (input  LOAD, BCD, DP_IN, output SEG, DP, AN, FRAME);
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver with a shadow/display register pair swapped only at
// frame boundaries. Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits.
//   state | meaning
//   BLANK | all anodes off for one cycle between digit slots
//   DRIVE | anode[index] on, segments show display digit[index]
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 16384,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    seg7_scan_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] sh_bcd_q, sh_bcd_d, disp_bcd_q, disp_bcd_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, disp_dp_q, disp_dp_d;
    logic                pending_q, pending_d;
    logic                frame_q, frame_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;

    logic                tick, last_idx, boundary;
    logic [DIGITS-1:0]   lz_blank;
    logic [DIGITS-1:0]   an_on;
    logic [6:0]          seg_on;
    logic                dp_on, dp_sel, blank_sel;
    logic [3:0]          digit;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    assign tick     = (presc_q == PW'(SCAN_DIV - 1));
    assign last_idx = (idx_q == IW'(DIGITS - 1));
    assign boundary = tick && (state_q == DRIVE) && last_idx;

    always_comb begin
        state_d    = state_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;
        idx_d      = idx_q;
        sh_bcd_d   = sh_bcd_q;
        sh_dp_d    = sh_dp_q;
        disp_bcd_d = disp_bcd_q;
        disp_dp_d  = disp_dp_q;
        pending_d  = pending_q;
        frame_d    = 1'b0;

        case (state_q)
            BLANK: state_d = DRIVE;
            DRIVE: begin
                if (tick) begin
                    state_d = BLANK;
                    idx_d   = last_idx ? '0 : idx_q + 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase

        if (boundary && pending_q) begin
            disp_bcd_d = sh_bcd_q;
            disp_dp_d  = sh_dp_q;
            pending_d  = 1'b0;
            frame_d    = 1'b1;
        end

        // A load on the boundary cycle lands in the shadow after the old shadow was taken.
        if (bus.LOAD) begin
            sh_bcd_d  = bus.BCD;
            sh_dp_d   = bus.DP_IN;
            pending_d = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lz_run;
    always_comb begin
        lz_blank = '0;
        lz_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lz_run && (disp_bcd_d[4*i +: 4] == 4'd0)) lz_blank[i] = 1'b1;
            else                                          lz_run      = 1'b0;
        end
    end
`else
    always_comb begin
        lz_blank = '0;
    end
`endif

    // Outputs are derived from next-cycle values so the registered pins line up with the state.
    always_comb begin
        an_on     = '0;
        digit     = 4'd0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                digit     = disp_bcd_d[4*i +: 4];
                dp_sel    = disp_dp_d[i];
                blank_sel = lz_blank[i];
                if (state_d == DRIVE) an_on[i] = 1'b1;
            end
        end
        seg_on = ((state_d == DRIVE) && !blank_sel) ? decode(digit) : 7'h00;
        dp_on  = (state_d == DRIVE) && dp_sel;
        an_d   = (AN_ACTIVE_LOW  != 0) ? ~an_on  : an_on;
        seg_d  = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
        dp_d   = (SEG_ACTIVE_LOW != 0) ? ~dp_on  : dp_on;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= BLANK;
            presc_q    <= '0;
            idx_q      <= '0;
            sh_bcd_q   <= '0;
            sh_dp_q    <= '0;
            disp_bcd_q <= '0;
            disp_dp_q  <= '0;
            pending_q  <= 1'b0;
            frame_q    <= 1'b0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_OFF;
            dp_q       <= DP_OFF;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            sh_bcd_q   <= sh_bcd_d;
            sh_dp_q    <= sh_dp_d;
            disp_bcd_q <= disp_bcd_d;
            disp_dp_q  <= disp_dp_d;
            pending_q  <= pending_d;
            frame_q    <= frame_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign bus.AN    = an_q;
    assign bus.SEG   = seg_q;
    assign bus.DP    = dp_q;
    assign bus.FRAME = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4, DIGITS=4, active-low outputs.
// Cycle k counts posedges since the last reset release; slot = k/4, k%4==0 is the blank cycle.
module tb_seg7_scan_driver;
    logic CLK;
    logic RESET;
    int   checks;
    int   errors;
    int   cyc;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    seg7_scan_if #(.DIGITS(4)) bus ();

    seg7_scan_driver #(
        .DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
    endtask

    task automatic goto(input int k);
        while (cyc < k) step(1);
    endtask

    task automatic load(input logic [15:0] bcd, input logic [3:0] dp);
        bus.LOAD  = 1'b1;
        bus.BCD   = bcd;
        bus.DP_IN = dp;
        step(1);
        bus.LOAD  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                       input logic dp_e, input logic fr_e);
        logic [12:0] got;
        logic [12:0] exp;
        got = {bus.AN, bus.SEG, bus.DP, bus.FRAME};
        exp = {an_e, seg_e, dp_e, fr_e};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed AN=%b SEG=%h DP=%b FRAME=%b, expected AN=%b SEG=%h DP=%b FRAME=%b",
                   tag, cyc, got[12:9], got[8:2], got[1], got[0], exp[12:9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        RESET     = 1'b1;
        bus.LOAD  = 1'b0;
        bus.BCD   = '0;
        bus.DP_IN = '0;

        // Reset held for 3 cycles
        step(3);
        chk("reset_idle", 4'b1111, 7'h7F, 1'b1, 1'b0);
        RESET = 1'b0;
        cyc   = 0;

        step(1);
        chk("first_drive_d0", 4'b1110, 7'h40, 1'b1, 1'b0);
        goto(2);
        load(16'h1234, 4'b0000);
        goto(4);
        chk("slot1_blank", 4'b1111, 7'h7F, 1'b1, 1'b0);
        goto(15);
        chk("zero_d3_lead", 4'b0111, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);
        goto(16);
        chk("frame_1234", 4'b1111, 7'h7F, 1'b1, 1'b1);
        goto(17);
        chk("d0_is_4", 4'b1110, 7'h19, 1'b1, 1'b0);
        goto(20);
        chk("blank_no_frame", 4'b1111, 7'h7F, 1'b1, 1'b0);
        goto(21);
        chk("d1_is_3", 4'b1101, 7'h30, 1'b1, 1'b0);
        goto(25);
        chk("d2_is_2", 4'b1011, 7'h24, 1'b1, 1'b0);
        goto(29);
        chk("d3_is_1", 4'b0111, 7'h79, 1'b1, 1'b0);
        goto(32);
        chk("no_frame_idle", 4'b1111, 7'h7F, 1'b1, 1'b0);

        // Two loads in one frame, then a third on the boundary cycle itself
        goto(33);
        load(16'h1111, 4'b0000);
        goto(35);
        chk("load_no_tear", 4'b1110, 7'h19, 1'b1, 1'b0);
        goto(40);
        load(16'h5678, 4'b0010);
        chk("load2_no_tear", 4'b1011, 7'h24, 1'b1, 1'b0);
        goto(47);
        load(16'h9999, 4'b0000);
        chk("frame_5678", 4'b1111, 7'h7F, 1'b1, 1'b1);
        goto(49);
        chk("d0_is_8", 4'b1110, 7'h00, 1'b1, 1'b0);
        goto(53);
        chk("d1_is_7_dp", 4'b1101, 7'h78, 1'b0, 1'b0);
        goto(57);
        chk("d2_is_6", 4'b1011, 7'h02, 1'b1, 1'b0);
        goto(61);
        chk("d3_is_5", 4'b0111, 7'h12, 1'b1, 1'b0);
        goto(64);
        chk("frame_9999", 4'b1111, 7'h7F, 1'b1, 1'b1);
        goto(65);
        chk("d0_is_9", 4'b1110, 7'h10, 1'b1, 1'b0);

        // Dash for code A and leading-zero handling
        goto(66);
        load(16'h00A7, 4'b1000);
        goto(77);
        chk("d3_still_9", 4'b0111, 7'h10, 1'b1, 1'b0);
        goto(80);
        chk("frame_00a7", 4'b1111, 7'h7F, 1'b1, 1'b1);
        goto(81);
        chk("d0_is_7", 4'b1110, 7'h78, 1'b1, 1'b0);
        goto(85);
        chk("d1_dash", 4'b1101, 7'h3F, 1'b1, 1'b0);
        goto(89);
        chk("d2_zero", 4'b1011, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);
        goto(93);
        chk("d3_zero_dp", 4'b0111, LZB ? 7'h7F : 7'h40, 1'b0, 1'b0);

        // Reset in the middle of DRIVE with a load pending
        goto(97);
        load(16'h4321, 4'b1111);
        goto(99);
        RESET = 1'b1;
        step(1);
        chk("midreset_off", 4'b1111, 7'h7F, 1'b1, 1'b0);
        RESET = 1'b0;
        cyc   = 0;
        goto(1);
        chk("post_reset_d0", 4'b1110, 7'h40, 1'b1, 1'b0);
        goto(5);
        chk("post_reset_d1", 4'b1101, LZB ? 7'h7F : 7'h40, 1'b1, 1'b0);
        goto(16);
        chk("post_reset_noframe", 4'b1111, 7'h7F, 1'b1, 1'b0);
        goto(17);
        chk("post_reset_disp0", 4'b1110, 7'h40, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
